wb_master_bridge: RTL

Wishbone classic initiator translating single load/store requests from the core's valid/ready data port into one Wishbone cycle each toward the peripheral bus (GPIO, data SRAM). Registers the request, drives CYC/STB until the responder ACKs or a bus timeout expires, then returns a single-cycle response. One transaction outstanding at a time; no bursts, no pipelining.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_timeout_ctr.sv | 30 +++
 rtl/wb_master_bridge.sv | 127 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone master bridge: default bus widths and the
// bridge FSM state encoding.
package wb_pkg;

    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StBus  = ST_BUS,
        StResp = ST_RESP
    } state_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Counts cycles spent waiting for ACK; flags the last permitted cycle before
// the bridge gives up on the responder.
module wb_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned   CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

    logic [CW-1:0] r_count;

    // Saturates at TIMEOUT so a stuck enable can never wrap back into range.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone classic initiator: one registered load/store per bus cycle, ended by
// ACK or timeout, answered with a single-cycle response strobe.
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int unsigned AW      = WB_AW,
    parameter int unsigned DW      = WB_DW,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_sel,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_adr,
    output logic [DW-1:0]   o_wb_dat,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic [DW-1:0]   i_wb_rdt,
    input  logic            i_wb_ack
);

    state_e r_state;
    state_e w_state_next;

    logic            r_we;
    logic [AW-1:0]   r_adr;
    logic [DW-1:0]   r_dat;
    logic [DW/8-1:0] r_sel;
    logic [DW-1:0]   r_rsp_rdata;
    logic            r_rsp_err;

    logic w_accept;
    logic w_in_bus;
    logic w_expired;
    logic w_bus_done;

    assign w_in_bus   = (r_state == StBus);
    assign w_bus_done = w_in_bus && (i_wb_ack || w_expired);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        o_wb_cyc     = 1'b0;
        o_wb_stb     = 1'b0;
        unique case (r_state)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = StBus;
                end
            end
            StBus: begin
                o_wb_cyc = 1'b1;
                o_wb_stb = 1'b1;
                if (i_wb_ack || w_expired) begin
                    w_state_next = StResp;
                end
            end
            StResp: begin
                rsp_valid    = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // ACK takes priority over a coincident timeout; writes never return data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we  <= req_we;
                r_adr <= req_addr;
                r_dat <= req_wdata;
                r_sel <= req_sel;
            end
            if (w_bus_done) begin
                r_rsp_rdata <= (i_wb_ack && !r_we) ? i_wb_rdt : '0;
                r_rsp_err   <= !i_wb_ack;
            end
        end
    end

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_accept),
        .i_enable  (w_in_bus),
        .o_expired (w_expired)
    );

    assign o_wb_we   = r_we;
    assign o_wb_adr  = r_adr;
    assign o_wb_dat  = r_dat;
    assign o_wb_sel  = r_sel;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
